// File: rtl/anita_trig_pkg.sv
// Shared types for the phi coincidence trigger: FSM state encoding and the pol/sector flat index helper.
// Purely declarative; no latency or flow-control implications.
package anita_trig_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } trig_state_t;

  // Flat bit index of sector 'sect' (taken mod num_phi) in polarisation 'pol'.
  function automatic int sect_idx(input int pol, input int sect, input int num_phi);
    return pol * num_phi + (sect % num_phi);
  endfunction

endpackage

// File: rtl/phi_window_count.sv
// Per-polarisation sliding-window popcount of WIN adjacent phi sectors, wrapping mod NUM_PHI.
// Combinational, zero latency; no flow control (the parent registers the compare).
module phi_window_count
  import anita_trig_pkg::*;
#(
  parameter int NUM_PHI = 16,
  parameter int WIN     = 2,
  parameter int CW      = $clog2(WIN + 1)
) (
  input  logic [NUM_PHI-1:0]         hits,
  output logic [NUM_PHI-1:0][CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_PHI; i++) begin
      for (int k = 0; k < WIN; k++) begin
        cnt[i] = cnt[i] + CW'(hits[sect_idx(0, i + k, NUM_PHI)]);
      end
    end
  end

endmodule

// File: rtl/phi_coincidence_trigger.sv
// N-of-WIN phi coincidence trigger with holdoff, disable, pattern latch and counters; phi_i to trig_o is 4 cycles.
// No backpressure: holdoff and disable drop coincidences; optional prescale via macro TRIG_PRESCALE_EN.
module phi_coincidence_trigger
  import anita_trig_pkg::*;
#(
  parameter int NUM_PHI = 16,
  parameter int NUM_POL = 2,
  parameter int WIN     = 2,
  parameter int HOLD_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk250_i,
  input  logic                       rst_i,
  input  logic [NUM_POL*NUM_PHI-1:0] phi_i,
  input  logic [NUM_POL*NUM_PHI-1:0] phi_mask_i,
  input  logic [$clog2(WIN+1)-1:0]   nreq_i,
  input  logic [HOLD_W-1:0]          holdoff_i,
  input  logic                       disable_i,
  input  logic [7:0]                 prescale_i,
  input  logic                       count_clr_i,
  output logic                       trig_o,
  output logic                       busy_o,
  output logic [NUM_POL*NUM_PHI-1:0] pattern_o,
  output logic [CNT_W-1:0]           trig_count_o,
  output logic [CNT_W-1:0]           raw_count_o
);

  localparam int NB = NUM_POL * NUM_PHI;
  localparam int CW = $clog2(WIN + 1);

  logic [NB-1:0] hit_r, hit_d, coinc, pat_c;
  logic          dis_r, any_c, any_d;
  logic [NUM_POL-1:0][NUM_PHI-1:0][CW-1:0] win_cnt;
  logic [CW-1:0] nreq_eff;
  trig_state_t   state;
  logic [HOLD_W-1:0] hcnt;
  logic          cand, fire;

  assign nreq_eff = (nreq_i == '0) ? CW'(1) : nreq_i;
  assign cand     = any_c & ~dis_r & (state == ST_IDLE);

  for (genvar p = 0; p < NUM_POL; p++) begin : g_pol
    phi_window_count #(
      .NUM_PHI(NUM_PHI),
      .WIN    (WIN),
      .CW     (CW)
    ) u_win (
      .hits(hit_r[sect_idx(p, 0, NUM_PHI) +: NUM_PHI]),
      .cnt (win_cnt[p])
    );
  end

  // hit_d / pat_c travel alongside coinc / any_c so the latched pattern matches the firing window.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      hit_r <= '0;
      dis_r <= 1'b0;
      hit_d <= '0;
      coinc <= '0;
      any_c <= 1'b0;
      pat_c <= '0;
      any_d <= 1'b0;
    end else begin
      hit_r <= phi_i & ~phi_mask_i;
      dis_r <= disable_i;
      hit_d <= hit_r;
      for (int p = 0; p < NUM_POL; p++) begin
        for (int i = 0; i < NUM_PHI; i++) begin
          coinc[sect_idx(p, i, NUM_PHI)] <= (win_cnt[p][i] >= nreq_eff);
        end
      end
      any_c <= |coinc;
      pat_c <= hit_d;
      any_d <= any_c;
    end
  end

`ifdef TRIG_PRESCALE_EN
  logic [7:0] psc;

  assign fire = cand & (psc == prescale_i);

  // psc only advances on candidates; a lowered prescale_i lets it run to 255 and wrap before matching.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      psc <= '0;
    end else if (cand) begin
      psc <= fire ? 8'd0 : psc + 8'd1;
    end
  end
`else
  logic unused_prescale;

  assign unused_prescale = ^prescale_i;
  assign fire            = cand;
`endif

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      trig_o    <= 1'b0;
      busy_o    <= 1'b0;
      pattern_o <= '0;
    end else begin
      trig_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            trig_o    <= 1'b1;
            pattern_o <= pat_c;
            hcnt      <= holdoff_i;
            if (holdoff_i != '0) begin
              state  <= ST_HOLD;
              busy_o <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hcnt <= HOLD_W'(1)) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            hcnt   <= '0;
          end else begin
            hcnt <= hcnt - HOLD_W'(1);
          end
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk250_i) begin
    if (rst_i || count_clr_i) begin
      trig_count_o <= '0;
      raw_count_o  <= '0;
    end else begin
      if (fire) trig_count_o <= trig_count_o + CNT_W'(1);
      if (any_c && !any_d) raw_count_o <= raw_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phi_coincidence_trigger.sv
// Self-checking bench for phi_coincidence_trigger: expected triggers queued at stimulus time, popped on trig_o.
// Prescale expectations follow TRIG_PRESCALE_EN.
module tb_phi_coincidence_trigger;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] phi, phi_mask;
  logic [1:0]  nreq;
  logic [7:0]  holdoff;
  logic        dis;
  logic [7:0]  prescale;
  logic        count_clr;
  logic        trig, busy;
  logic [31:0] pattern;
  logic [15:0] trig_count, raw_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pat;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

`ifdef TRIG_PRESCALE_EN
  localparam bit PSC_EN = 1'b1;
`else
  localparam bit PSC_EN = 1'b0;
`endif

  phi_coincidence_trigger dut (
    .clk250_i    (clk),
    .rst_i       (rst),
    .phi_i       (phi),
    .phi_mask_i  (phi_mask),
    .nreq_i      (nreq),
    .holdoff_i   (holdoff),
    .disable_i   (dis),
    .prescale_i  (prescale),
    .count_clr_i (count_clr),
    .trig_o      (trig),
    .busy_o      (busy),
    .pattern_o   (pattern),
    .trig_count_o(trig_count),
    .raw_count_o (raw_count)
  );

  always #2 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every trig_o pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && trig === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_trig cyc=%0d pattern=%h", cyc, pattern);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc !== cyc || pattern !== mon_e.pat) begin
          miscompares++;
          $display("FAIL trig_event got cyc=%0d pat=%h want cyc=%0d pat=%h",
                   cyc, pattern, mon_e.cyc, mon_e.pat);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counters();
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    step(1);
  endtask

  task automatic pulse(input logic [31:0] p);
    phi = p;
    step(1);
    phi = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; phi = '0; phi_mask = '0; nreq = 2'd2; holdoff = '0;
    dis = 1'b0; prescale = '0; count_clr = 1'b0;
    step(3);
    vectors += 5;
    if (trig !== 1'b0) begin miscompares++; $display("FAIL rst_trig got=%b want=0", trig); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (pattern !== 32'h0) begin miscompares++; $display("FAIL rst_pattern got=%h want=0", pattern); end
    if (trig_count !== 16'd0) begin miscompares++; $display("FAIL rst_trig_count got=%0d want=0", trig_count); end
    if (raw_count !== 16'd0) begin miscompares++; $display("FAIL rst_raw_count got=%0d want=0", raw_count); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    int nb = 0;
    holdoff = 8'd31;
    clear_counters();
    exp_q.push_back('{cyc + 4, 32'h0000_0018});
    pulse(32'h0000_0018);
    step(3);
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) nb++;
      step(1);
    end
    vectors += 4;
    if (nb !== 31) begin miscompares++; $display("FAIL basic_busy_cycles got=%0d want=31", nb); end
    if (trig_count !== 16'd1) begin miscompares++; $display("FAIL basic_trig_count got=%0d want=1", trig_count); end
    if (raw_count !== 16'd1) begin miscompares++; $display("FAIL basic_raw_count got=%0d want=1", raw_count); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap();
    holdoff = 8'd0;
    clear_counters();
    exp_q.push_back('{cyc + 4, 32'h0000_8001});
    pulse(32'h0000_8001);
    step(8);
    pulse(32'h0000_8000);
    step(8);
    phi_mask = 32'h0000_0001;
    pulse(32'h0000_8001);
    step(8);
    phi_mask = '0;
    vectors += 3;
    if (trig_count !== 16'd1) begin miscompares++; $display("FAIL wrap_trig_count got=%0d want=1", trig_count); end
    if (pattern !== 32'h0000_8001) begin miscompares++; $display("FAIL wrap_pattern_hold got=%h want=00008001", pattern); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_held();
    int c;
    holdoff = 8'd9;
    clear_counters();
    c = cyc;
    for (int k = 0; k < 10; k++) exp_q.push_back('{c + 4 + 10 * k, 32'h0000_0018});
    phi = 32'h0000_0018;
    step(100);
    phi = '0;
    step(12);
    vectors += 3;
    if (trig_count !== 16'd10) begin miscompares++; $display("FAIL held_trig_count got=%0d want=10", trig_count); end
    if (raw_count !== 16'd1) begin miscompares++; $display("FAIL held_raw_count got=%0d want=1", raw_count); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL held_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_disable();
    holdoff = 8'd0;
    dis = 1'b1;
    step(2);
    clear_counters();
    for (int k = 0; k < 5; k++) begin
      pulse(32'h0003_0000);
      step(7);
    end
    vectors += 3;
    if (trig_count !== 16'd0) begin miscompares++; $display("FAIL dis_trig_count got=%0d want=0", trig_count); end
    if (raw_count !== 16'd5) begin miscompares++; $display("FAIL dis_raw_count got=%0d want=5", raw_count); end
    if (pattern !== 32'h0000_0018) begin miscompares++; $display("FAIL dis_pattern_hold got=%h want=00000018", pattern); end
    dis = 1'b0;
    step(3);
    exp_q.push_back('{cyc + 4, 32'h0000_0018});
    pulse(32'h0000_0018);
    step(2);
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    vectors += 2;
    if (trig_count !== 16'd0) begin miscompares++; $display("FAIL clr_trig_count got=%0d want=0", trig_count); end
    if (raw_count !== 16'd0) begin miscompares++; $display("FAIL clr_raw_count got=%0d want=0", raw_count); end
    step(4);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL clr_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_hold();
    int c;
    holdoff = 8'd40;
    clear_counters();
    c = cyc;
    exp_q.push_back('{c + 4, 32'h0000_0018});
    pulse(32'h0000_0018);
    step(23);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rh_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    step(1);
    vectors += 5;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rh_busy got=%b want=0", busy); end
    if (trig !== 1'b0) begin miscompares++; $display("FAIL rh_trig got=%b want=0", trig); end
    if (pattern !== 32'h0) begin miscompares++; $display("FAIL rh_pattern got=%h want=0", pattern); end
    if (trig_count !== 16'd0) begin miscompares++; $display("FAIL rh_trig_count got=%0d want=0", trig_count); end
    if (raw_count !== 16'd0) begin miscompares++; $display("FAIL rh_raw_count got=%0d want=0", raw_count); end
    rst = 1'b0;
    holdoff = 8'd0;
    step(1);
    exp_q.push_back('{cyc + 4, 32'h0000_0006});
    pulse(32'h0000_0006);
    step(8);
    vectors += 2;
    if (trig_count !== 16'd1) begin miscompares++; $display("FAIL rh_after_count got=%0d want=1", trig_count); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rh_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_prescale();
    int want;
    prescale = 8'd3;
    holdoff = 8'd0;
    clear_counters();
    for (int n = 1; n <= 12; n++) begin
      if (!PSC_EN || (n % 4 == 0)) exp_q.push_back('{cyc + 4, 32'h0000_0018});
      pulse(32'h0000_0018);
      step(7);
    end
    want = PSC_EN ? 3 : 12;
    vectors += 3;
    if (trig_count !== 16'(want)) begin miscompares++; $display("FAIL psc_trig_count got=%0d want=%0d", trig_count, want); end
    if (raw_count !== 16'd12) begin miscompares++; $display("FAIL psc_raw_count got=%0d want=12", raw_count); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL psc_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    prescale = 8'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_held();
    test_disable();
    test_reset_hold();
    test_prescale();
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
